// File: rtl/cgp_array_serial.sv
`default_nettype none
// ============================================================================
// Module   : cgp_array_serial
// Desc     : Serially configured CGP logic-element array, evaluated one column
//            per clock. Optional stream parity check: CGP_CFG_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module cgp_array_serial #(
  parameter int N_IN   = 8,
  parameter int N_OUT  = 8,
  parameter int N_ROWS = 5,
  parameter int N_COLS = 5,
  parameter int SEL_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_done,
  output logic             cfg_error,
  input  logic             eval_start,
  input  logic [N_IN-1:0]  chrom_in,
  output logic             busy,
  output logic             out_valid,
  output logic [N_OUT-1:0] chrom_out
);

  localparam int c_N_LE       = N_ROWS * N_COLS;
  localparam int c_LE_CFG_W   = 3 + 2 * SEL_W;
  localparam int c_OUT_BASE   = c_N_LE * c_LE_CFG_W;
  localparam int c_CFG_BITS   = c_OUT_BASE + N_OUT * SEL_W;
  localparam int c_SIG_W      = N_IN + c_N_LE;
  localparam int c_PAD_W      = 1 << SEL_W;
`ifdef CGP_CFG_PARITY_EN
  localparam int c_STREAM_BITS = c_CFG_BITS + 1;
`else
  localparam int c_STREAM_BITS = c_CFG_BITS;
`endif
  localparam int c_CNT_W      = $clog2(c_STREAM_BITS + 1);
  localparam int c_IDX_W      = $clog2(c_CFG_BITS);
  localparam int c_LE_IDX_W   = (c_N_LE > 1) ? $clog2(c_N_LE) : 1;
  localparam int c_COL_W      = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  localparam logic [c_CNT_W-1:0] c_CFG_END  = c_CNT_W'(c_CFG_BITS);
`ifndef CGP_CFG_PARITY_EN
  localparam logic [c_CNT_W-1:0] c_CFG_LAST = c_CNT_W'(c_CFG_BITS - 1);
`endif
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(N_COLS - 1);
  localparam logic [SEL_W:0]     c_SIG_LIM  = (SEL_W + 1)'(c_SIG_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [c_CFG_BITS-1:0]   cfg_q;
  logic [c_CNT_W-1:0]      cnt_q;
  logic                    done_q;
  logic [N_IN-1:0]         in_q;
  logic [c_COL_W-1:0]      col_q;
  logic [c_N_LE-1:0]       le_q;
  logic [c_N_LE-1:0]       le_d;
  logic                    busy_q;
  logic                    valid_q;
  logic [N_OUT-1:0]        out_q;
  logic [N_OUT-1:0]        out_d;
`ifdef CGP_CFG_PARITY_EN
  logic                    par_q;
  logic                    err_q;
`endif

  logic [c_PAD_W-1:0]      sig_pad;
  logic [c_PAD_W-1:0]      sig_nxt;
  logic [SEL_W:0]          col_lim;
  logic [c_LE_CFG_W-1:0]   le_cfg  [c_N_LE];
  logic [SEL_W-1:0]        out_sel [N_OUT];
  logic [N_ROWS-1:0]       le_res;

  function automatic logic le_fn(input logic [2:0] f, input logic a, input logic b);
    logic y;
    case (f)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = a ^ b;
      3'd3:    y = ~(a & b);
      3'd4:    y = ~(a | b);
      3'd5:    y = ~(a ^ b);
      3'd6:    y = ~a;
      default: y = a;
    endcase
    return y;
  endfunction

  // Unused high select codes read as zero through the padding.
  assign sig_pad = c_PAD_W'({le_q, in_q});
  assign sig_nxt = c_PAD_W'({le_d, in_q});
  assign col_lim = (SEL_W + 1)'(N_IN) + (SEL_W + 1)'(col_q) * (SEL_W + 1)'(N_ROWS);

  for (genvar k = 0; k < c_N_LE; k++) begin : g_le_cfg
    assign le_cfg[k] = cfg_q[k*c_LE_CFG_W +: c_LE_CFG_W];
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_out_sel
    assign out_sel[o] = cfg_q[c_OUT_BASE + o*SEL_W +: SEL_W];
    assign out_d[o]   = ({1'b0, out_sel[o]} < c_SIG_LIM) ? sig_nxt[out_sel[o]] : 1'b0;
  end

  // One shared evaluator per row; the active column picks which LE it serves.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    logic [c_LE_IDX_W-1:0] k_idx;
    logic [c_LE_CFG_W-1:0] cfg;
    logic [SEL_W-1:0]      sel_a;
    logic [SEL_W-1:0]      sel_b;
    logic                  a;
    logic                  b;

    assign k_idx = c_LE_IDX_W'(col_q) * c_LE_IDX_W'(N_ROWS) + c_LE_IDX_W'(r);
    assign cfg   = le_cfg[k_idx];
    assign sel_a = cfg[SEL_W-1:0];
    assign sel_b = cfg[2*SEL_W-1:SEL_W];
    assign a     = ({1'b0, sel_a} < col_lim) ? sig_pad[sel_a] : 1'b0;
    assign b     = ({1'b0, sel_b} < col_lim) ? sig_pad[sel_b] : 1'b0;
    assign le_res[r] = le_fn(cfg[c_LE_CFG_W-1 -: 3], a, b);
  end

  for (genvar k = 0; k < c_N_LE; k++) begin : g_le_next
    assign le_d[k] = (col_q == c_COL_W'(k / N_ROWS)) ? le_res[k % N_ROWS] : le_q[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      in_q    <= '0;
      col_q   <= '0;
      le_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
`ifdef CGP_CFG_PARITY_EN
      par_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_EVAL: begin
          le_q <= le_d;
          if (col_q == c_COL_LAST) begin
            out_q   <= out_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_OUT;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          if (cfg_start) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
`ifdef CGP_CFG_PARITY_EN
            par_q  <= 1'b0;
            err_q  <= 1'b0;
`endif
          end else begin
            if (cfg_valid && (cnt_q < c_CFG_END)) begin
              cfg_q[cnt_q[c_IDX_W-1:0]] <= cfg_bit;
              cnt_q <= cnt_q + 1'b1;
`ifdef CGP_CFG_PARITY_EN
              par_q <= par_q ^ cfg_bit;
`else
              if (cnt_q == c_CFG_LAST) done_q <= 1'b1;
`endif
            end
`ifdef CGP_CFG_PARITY_EN
            else if (cfg_valid && (cnt_q == c_CFG_END)) begin
              cnt_q <= cnt_q + 1'b1;
              if (par_q ^ cfg_bit) err_q  <= 1'b1;
              else                 done_q <= 1'b1;
            end
`endif
            if (eval_start && done_q) begin
              in_q    <= chrom_in;
              col_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_EVAL;
            end
          end
        end
      endcase
    end
  end

  assign cfg_done  = done_q;
`ifdef CGP_CFG_PARITY_EN
  assign cfg_error = err_q;
`else
  assign cfg_error = 1'b0;
`endif
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign chrom_out = out_q;

endmodule
`default_nettype wire
